// File: rtl/pwm_pkg.sv
// Shared state encoding and constants for the PWM capture block.
// Pure declarations; no logic, no latency, no flow control.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } state_t;

    localparam int DUTY_MAX = 255;

endpackage

// File: rtl/pwm_capture_if.sv
// Capture-side bundle: raw PWM line in, measurement results out.
// Results are qualified by a one-cycle valid pulse; there is no backpressure.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             pwm_in;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic [7:0]       duty;
    logic             valid;
    logic             stuck;
    logic             stuck_lvl;

    modport master (
        input  pwm_in,
        output high_time, period, duty, valid, stuck, stuck_lvl
    );

    modport slave (
        output pwm_in,
        input  high_time, period, duty, valid, stuck, stuck_lvl
    );
endinterface

// File: rtl/pwm_in_sync.sv
// Synchronizer + registered edge detect for the PWM line; optional PWM_CAPTURE_GLITCH_FILTER_EN filter.
// Latency 3 cycles pin-to-edge-pulse (+FILT_LEN when filtered); no backpressure.
module pwm_in_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic pwm_clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic pwm_s_d;

    always_ff @(posedge pwm_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int RUN_W = $clog2(FILT_LEN + 1);

    logic [RUN_W-1:0] run;
    logic             filt;

    // run counts consecutive samples disagreeing with the accepted level;
    // delay is identical for both polarities so measured widths are unbiased.
    always_ff @(posedge pwm_clk or negedge rst_n) begin
        if (!rst_n) begin
            run  <= '0;
            filt <= 1'b0;
        end else if (sync2 == filt) begin
            run <= '0;
        end else if (run == RUN_W'(FILT_LEN - 1)) begin
            filt <= sync2;
            run  <= '0;
        end else begin
            run <= run + 1'b1;
        end
    end

    assign pwm_s = filt;
`else
    assign pwm_s = sync2;
`endif

    always_ff @(posedge pwm_clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_s_d <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            pwm_s_d <= pwm_s;
            rise    <= pwm_s & ~pwm_s_d;
            fall    <= ~pwm_s & pwm_s_d;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM receive decoder: high time, period, 8-bit duty and stuck-line detect; PWM_CAPTURE_GLITCH_FILTER_EN adds a filter.
// valid pulses 4 pwm_clk after a pwm_in rise (+FILT_LEN filtered); results are fire-and-forget, no backpressure.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 65535,
    parameter int FILT_LEN = 3
) (
    input  logic          pwm_clk,
    input  logic          rst_n,
    pwm_capture_if.master bus
);

    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic pwm_s;
    logic rise;
    logic fall;

    pwm_in_sync #(
        .FILT_LEN (FILT_LEN)
    ) u_sync (
        .pwm_clk (pwm_clk),
        .rst_n   (rst_n),
        .pwm_in  (bus.pwm_in),
        .pwm_s   (pwm_s),
        .rise    (rise),
        .fall    (fall)
    );

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] high_time_r;
    logic [CNT_W-1:0] period_r;
    logic [7:0]       duty_r;
    logic             valid_r;
    logic             stuck_r;
    logic             stuck_lvl_r;
    logic             timeout;

    function automatic logic [7:0] sat_duty(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(DUTY_MAX)) ? 8'(DUTY_MAX) : v[7:0];
    endfunction

    // An edge in the same cycle always beats the timeout.
    assign timeout = (idle_cnt == TO_LIM) && !rise && !fall;

    always_ff @(posedge pwm_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idle_cnt <= '0;
        end else begin
            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (rise || fall) begin
                idle_cnt <= CNT_W'(1);
            end else if (idle_cnt != TO_LIM) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge pwm_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hi_cnt      <= '0;
            high_time_r <= '0;
            period_r    <= '0;
            duty_r      <= '0;
            valid_r     <= 1'b0;
            stuck_r     <= 1'b0;
            stuck_lvl_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (timeout && state != STUCK) begin
                state       <= STUCK;
                stuck_r     <= 1'b1;
                stuck_lvl_r <= pwm_s;
                duty_r      <= pwm_s ? 8'(DUTY_MAX) : 8'd0;
                valid_r     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            hi_cnt <= cnt;
                            state  <= LOW;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            high_time_r <= hi_cnt;
                            period_r    <= cnt;
                            duty_r      <= sat_duty(hi_cnt);
                            valid_r     <= 1'b1;
                            state       <= HIGH;
                        end
                    end
                    STUCK: begin
                        // Track the line while stuck; first rise re-arms like IDLE.
                        stuck_lvl_r <= pwm_s;
                        duty_r      <= pwm_s ? 8'(DUTY_MAX) : 8'd0;
                        if (rise) begin
                            stuck_r <= 1'b0;
                            state   <= HIGH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.high_time = high_time_r;
    assign bus.period    = period_r;
    assign bus.duty      = duty_r;
    assign bus.valid     = valid_r;
    assign bus.stuck     = stuck_r;
    assign bus.stuck_lvl = stuck_lvl_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: generator-style waveforms with hand-computed results.
// Filter-specific glitch stimulus runs only when PWM_CAPTURE_GLITCH_FILTER_EN is defined.
module tb_pwm_capture;

    localparam int CNT_W    = 16;
    localparam int TIMEOUT  = 1000;
    localparam int FILT_LEN = 3;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT = 4 + FILT_LEN;
`else
    localparam int LAT = 4;
`endif

    logic pwm_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_miss  = 0;

    int q_ht[$];
    int q_per[$];
    int q_duty[$];
    int q_cyc[$];
    int rise_q[$];

    pwm_capture_if #(.CNT_W(CNT_W)) bus ();

    pwm_capture #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .pwm_clk (pwm_clk),
        .rst_n   (rst_n),
        .bus     (bus.master)
    );

    always #5 pwm_clk = ~pwm_clk;

    always @(posedge pwm_clk) cyc++;

    always @(negedge pwm_clk) begin
        if (bus.valid) begin
            q_ht.push_back(int'(bus.high_time));
            q_per.push_back(int'(bus.period));
            q_duty.push_back(int'(bus.duty));
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pwm_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.pwm_in = 1'b0;
        tick(3);
        q_ht.delete();
        q_per.delete();
        q_duty.delete();
        q_cyc.delete();
        rise_q.delete();
        rst_n = 1'b1;
        tick(1);
    endtask

    // One generator period: high for hi cycles, low for the rest; glitch drops
    // the line for two cycles in the middle of the high phase.
    task automatic pwm_period(input int hi, input int per, input bit glitch);
        for (int i = 0; i < per; i++) begin
            bus.pwm_in = (i < hi);
            if (glitch && (i == hi / 2 || i == hi / 2 + 1)) bus.pwm_in = 1'b0;
            if (i == 0) rise_q.push_back(cyc);
            tick(1);
        end
    endtask

    initial begin
        bus.pwm_in = 1'b0;
        rst_n      = 1'b0;
        tick(2);
        chk("rst_valid",     bus.valid,     0);
        chk("rst_stuck",     bus.stuck,     0);
        chk("rst_high_time", bus.high_time, 0);
        chk("rst_period",    bus.period,    0);
        chk("rst_duty",      bus.duty,      0);

        // duty 64 of 256
        do_reset();
        repeat (4) pwm_period(64, 256, 1'b0);
        tick(10);
        chk("d64_count", q_ht.size(), 3);
        if (q_ht.size() >= 1 && rise_q.size() >= 2) begin
            chk("d64_high_time", q_ht[0], 64);
            chk("d64_period",    q_per[0], 256);
            chk("d64_duty",      q_duty[0], 64);
            chk("d64_latency",   q_cyc[0] - rise_q[1], LAT);
        end

        // duty change 64 -> 200 mid-run
        do_reset();
        repeat (3) pwm_period(64, 256, 1'b0);
        repeat (3) pwm_period(200, 256, 1'b0);
        tick(10);
        chk("chg_count", q_ht.size(), 5);
        if (q_ht.size() >= 5) begin
            chk("chg_last_old",  q_ht[2], 64);
            chk("chg_first_new", q_ht[3], 200);
            chk("chg_period",    q_per[3], 256);
            chk("chg_duty",      q_duty[4], 200);
        end

        // stuck low, then recovery
        do_reset();
        repeat (3) pwm_period(100, 256, 1'b0);
        tick(TIMEOUT + 10);
        chk("stk_count",     q_ht.size(), 3);
        chk("stk_stuck",     bus.stuck, 1);
        chk("stk_lvl",       bus.stuck_lvl, 0);
        chk("stk_duty",      bus.duty, 0);
        chk("stk_high_hold", bus.high_time, 100);
        chk("stk_per_hold",  bus.period, 256);
        bus.pwm_in = 1'b1;
        rise_q.push_back(cyc);
        tick(6);
        chk("stk_clear",     bus.stuck, 0);
        chk("stk_no_valid",  q_ht.size(), 3);
        tick(58);
        bus.pwm_in = 1'b0;
        tick(192);
        pwm_period(64, 256, 1'b0);
        tick(10);
        chk("stk_resume_count", q_ht.size(), 4);
        if (q_ht.size() >= 4) begin
            chk("stk_resume_high", q_ht[3], 64);
            chk("stk_resume_per",  q_per[3], 256);
        end

        // stuck high
        do_reset();
        bus.pwm_in = 1'b1;
        tick(TIMEOUT + 20);
        chk("stkh_stuck", bus.stuck, 1);
        chk("stkh_lvl",   bus.stuck_lvl, 1);
        chk("stkh_duty",  bus.duty, 255);
        chk("stkh_count", q_ht.size(), 1);

        // duty 255: one-cycle low
        do_reset();
        repeat (3) pwm_period(255, 256, 1'b0);
        tick(10);
        chk("d255_count", q_ht.size(), 2);
        if (q_ht.size() >= 1) begin
            chk("d255_high_time", q_ht[0], 255);
            chk("d255_period",    q_per[0], 256);
            chk("d255_duty",      q_duty[0], 255);
        end
        chk("d255_stuck", bus.stuck, 0);

        // high time above 255 saturates duty
        do_reset();
        repeat (2) pwm_period(300, 512, 1'b0);
        tick(10);
        chk("sat_count", q_ht.size(), 1);
        if (q_ht.size() >= 1) begin
            chk("sat_high_time", q_ht[0], 300);
            chk("sat_period",    q_per[0], 512);
            chk("sat_duty",      q_duty[0], 255);
        end

        // reset mid-HIGH
        do_reset();
        repeat (3) pwm_period(64, 256, 1'b0);
        bus.pwm_in = 1'b1;
        tick(30);
        rst_n = 1'b0;
        #1;
        chk("mrst_high_time", bus.high_time, 0);
        chk("mrst_period",    bus.period, 0);
        chk("mrst_duty",      bus.duty, 0);
        do_reset();
        pwm_period(64, 256, 1'b0);
        chk("mrst_one_rise", q_ht.size(), 0);
        pwm_period(64, 256, 1'b0);
        tick(10);
        chk("mrst_two_rise", q_ht.size(), 1);
        if (q_ht.size() >= 1) chk("mrst_high_time2", q_ht[0], 64);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        // 2-cycle glitches on a 50% wave must be invisible
        do_reset();
        repeat (4) pwm_period(128, 256, 1'b1);
        tick(10);
        chk("glt_count", q_ht.size(), 3);
        if (q_ht.size() >= 3) begin
            chk("glt_high_time", q_ht[2], 128);
            chk("glt_period",    q_per[2], 256);
            chk("glt_duty",      q_duty[2], 128);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
